ssb_sync_ctrl: RTL and testbench

Acquisition/tracking supervisor for the SSB receive chain. Sequences the PSS detector between search, track and pause, and latches the detected N_id_2 and N_id. Keeps a sample-count timebase of the SSB period, declares loss of lock after repeated missed PSS, and gates CFO updates into the DDS phase accumulator. Sits beside frame_sync and drives the PSS detector's mode and requested-N_id_2 inputs.

---
 rtl/rx_pkg.sv | 22 ++
 rtl/ssb_sync_ctrl_if.sv | 67 ++++++
 rtl/ssb_sync_ctrl.sv | 151 +++++++++++++++
 tb/tb_ssb_sync_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared receive-chain definitions: PSS detector mode encoding,
// sync supervisor state encoding and cell-ID field widths.
package rx_pkg;

  localparam int N_ID_W   = 10;
  localparam int N_ID_2_W = 2;

  // PSS detector operating mode, shared with the detector and frame_sync
  typedef enum logic [1:0] {
    MODE_SEARCH = 2'd0,
    MODE_TRACK  = 2'd1,
    MODE_PAUSE  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_SEARCH     = 2'd0,
    ST_WAIT_SSS   = 2'd1,
    ST_TRACK_WAIT = 2'd2,
    ST_TRACK_WIN  = 2'd3
  } state_e;

endpackage

// File: rtl/ssb_sync_ctrl_if.sv
// Bundle between the SSB sync supervisor and the PSS/SSS detectors.
// master: detector/sample side driving events; slave: the supervisor.
// Inputs to the supervisor: sample strobe, restart, PSS and SSS pulses.
// Outputs: detector mode, requested N_id_2, CFO gate, lock status,
// latched IDs, loss-of-lock pulse, miss count and debug state.
interface ssb_sync_ctrl_if
  import rx_pkg::*;
#(
  parameter int MAX_MISSES = 3
) ();

  localparam int MISS_W = $clog2(MAX_MISSES + 1);

  logic                sample_valid_i;
  logic                restart_i;
  logic                N_id_2_valid_i;
  logic [N_ID_2_W-1:0] N_id_2_i;
  logic                N_id_valid_i;
  logic [N_ID_W-1:0]   N_id_i;

  logic [1:0]          PSS_detector_mode_o;
  logic [N_ID_2_W-1:0] requested_N_id_2_o;
  logic                CFO_en_o;
  logic                locked_o;
  logic [N_ID_2_W-1:0] N_id_2_o;
  logic [N_ID_W-1:0]   N_id_o;
  logic                lock_lost_o;
  logic [MISS_W-1:0]   miss_cnt_o;
  logic [1:0]          state_o;

  modport master (
    output sample_valid_i,
    output restart_i,
    output N_id_2_valid_i,
    output N_id_2_i,
    output N_id_valid_i,
    output N_id_i,
    input  PSS_detector_mode_o,
    input  requested_N_id_2_o,
    input  CFO_en_o,
    input  locked_o,
    input  N_id_2_o,
    input  N_id_o,
    input  lock_lost_o,
    input  miss_cnt_o,
    input  state_o
  );

  modport slave (
    input  sample_valid_i,
    input  restart_i,
    input  N_id_2_valid_i,
    input  N_id_2_i,
    input  N_id_valid_i,
    input  N_id_i,
    output PSS_detector_mode_o,
    output requested_N_id_2_o,
    output CFO_en_o,
    output locked_o,
    output N_id_2_o,
    output N_id_o,
    output lock_lost_o,
    output miss_cnt_o,
    output state_o
  );

endinterface

// File: rtl/ssb_sync_ctrl.sv
// SSB acquisition/tracking supervisor: sequences the PSS detector
// between search, track and pause, latches N_id_2/N_id, keeps an
// SSB-period sample timebase and declares loss of lock on misses.
// Ports: clk_i, reset_i (sync, active-high), bus (slave modport).
module ssb_sync_ctrl
  import rx_pkg::*;
#(
  parameter int SSB_PERIOD  = 38400,
  parameter int TRACK_WIN   = 16,
  parameter int MAX_MISSES  = 3,
  parameter int SSS_TIMEOUT = 2048
) (
  input logic           clk_i,
  input logic           reset_i,
  ssb_sync_ctrl_if.slave bus
);

  localparam int CNT_W  = $clog2(SSB_PERIOD + TRACK_WIN);
  localparam int MISS_W = $clog2(MAX_MISSES + 1);
  localparam int HALF   = TRACK_WIN / 2;

  localparam logic [CNT_W-1:0] OPEN_AT =
    CNT_W'(SSB_PERIOD - HALF - 1);
  localparam logic [CNT_W-1:0] CLOSE_AT =
    CNT_W'(SSB_PERIOD + HALF - 1);
  localparam logic [CNT_W-1:0] TMO_AT =
    CNT_W'(SSS_TIMEOUT - 1);
  // after a miss, resume as if the PSS had arrived on time
  localparam logic [CNT_W-1:0] REANCHOR = CNT_W'(HALF);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MAX_MISSES);

  state_e              state;
  logic [CNT_W-1:0]    cnt;
  logic [MISS_W-1:0]   miss_cnt;
  logic                locked;
  logic                lock_lost;
  logic [N_ID_2_W-1:0] nid2;
  logic [N_ID_W-1:0]   nid;

  logic                sv;
  logic                pss_hit;
  logic                win_close;
  logic                sss_tmo;
  logic                win_open;
  logic [MISS_W-1:0]   miss_nxt;

  mode_e               mode;
  logic                cfo_en;

  assign sv        = bus.sample_valid_i;
  assign pss_hit   = bus.N_id_2_valid_i &&
                     (bus.N_id_2_i == nid2);
  assign win_close = sv && (cnt == CLOSE_AT);
  assign win_open  = sv && (cnt == OPEN_AT);
  assign sss_tmo   = sv && (cnt == TMO_AT);
  assign miss_nxt  = miss_cnt + 1'b1;

  always_ff @(posedge clk_i) begin
    lock_lost <= 1'b0;
    if (reset_i) begin
      state    <= ST_SEARCH;
      cnt      <= '0;
      miss_cnt <= '0;
      locked   <= 1'b0;
      nid2     <= '0;
      nid      <= '0;
    end else if (bus.restart_i) begin
      state    <= ST_SEARCH;
      cnt      <= '0;
      miss_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      if (sv && state != ST_SEARCH)
        cnt <= cnt + 1'b1;
      unique case (state)
        ST_SEARCH: begin
          if (bus.N_id_2_valid_i) begin
            nid2  <= bus.N_id_2_i;
            cnt   <= '0;
            state <= ST_WAIT_SSS;
          end
        end
        ST_WAIT_SSS: begin
          if (bus.N_id_valid_i) begin
            nid      <= bus.N_id_i;
            locked   <= 1'b1;
            miss_cnt <= '0;
            state    <= ST_TRACK_WAIT;
          end else if (sss_tmo) begin
            cnt   <= '0;
            state <= ST_SEARCH;
          end
        end
        ST_TRACK_WAIT: begin
          if (win_open)
            state <= ST_TRACK_WIN;
        end
        ST_TRACK_WIN: begin
          if (pss_hit) begin
            cnt      <= '0;
            miss_cnt <= '0;
            state    <= ST_TRACK_WAIT;
          end else if (win_close) begin
            if (miss_nxt == MISS_MAX) begin
              cnt       <= '0;
              miss_cnt  <= '0;
              locked    <= 1'b0;
              lock_lost <= 1'b1;
              state     <= ST_SEARCH;
            end else begin
              cnt      <= REANCHOR;
              miss_cnt <= miss_nxt;
              state    <= ST_TRACK_WAIT;
            end
          end
        end
        default: state <= ST_SEARCH;
      endcase
    end
  end

  always_comb begin
    mode   = MODE_PAUSE;
    cfo_en = 1'b0;
    unique case (1'b1)
      (state == ST_SEARCH): begin
        mode   = MODE_SEARCH;
        cfo_en = 1'b1;
      end
      (state == ST_TRACK_WIN): begin
        mode   = MODE_TRACK;
        cfo_en = 1'b1;
      end
      default: begin
        mode   = MODE_PAUSE;
        cfo_en = 1'b0;
      end
    endcase
  end

  assign bus.PSS_detector_mode_o = mode;
  assign bus.requested_N_id_2_o  = nid2;
  assign bus.CFO_en_o            = cfo_en;
  assign bus.locked_o            = locked;
  assign bus.N_id_2_o            = nid2;
  assign bus.N_id_o              = nid;
  assign bus.lock_lost_o         = lock_lost;
  assign bus.miss_cnt_o          = miss_cnt;
  assign bus.state_o             = state;

endmodule

// File: tb/tb_ssb_sync_ctrl.sv
// Bench for ssb_sync_ctrl: directed acquisition/track/loss scenarios
// then randomized traffic, scored against an SSB-timeline model.
module tb_ssb_sync_ctrl;
  import rx_pkg::*;

  localparam int P  = 100;
  localparam int W  = 8;
  localparam int MM = 3;
  localparam int TO = 40;
  localparam int H  = W / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ssb_sync_ctrl_if #(.MAX_MISSES(MM)) bus ();

  ssb_sync_ctrl #(
    .SSB_PERIOD (P),
    .TRACK_WIN  (W),
    .MAX_MISSES (MM),
    .SSS_TIMEOUT(TO)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] mode;
    logic [1:0] req;
    logic       cfo;
    logic       lk;
    logic [1:0] n2;
    logic [9:0] n;
    logic       lost;
    logic [1:0] miss;
  } obs_t;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   lost_seen   = 0;

  // Model: phase 0 search, 1 awaiting SSS, 2 locked.
  // Locked timing is an anchor A on the global sample count S:
  // samples since the last (real or assumed) PSS = S - A.
  int         m_ph   = 0;
  int         m_S    = 0;
  int         m_A    = 0;
  int         m_miss = 0;
  logic       m_lk   = 1'b0;
  logic       m_lost = 1'b0;
  logic [1:0] m_n2   = 2'd0;
  logic [9:0] m_n    = 10'd0;
  logic       sv_ph  = 1'b0;
  int         hitp   = 0;

  function automatic obs_t m_obs();
    obs_t o;
    int   st;
    if (m_ph == 0) st = 0;
    else if (m_ph == 1) st = 1;
    else st = ((m_S - m_A) >= P - H) ? 3 : 2;
    o.st   = 2'(st);
    o.mode = (st == 0) ? 2'd0 : ((st == 3) ? 2'd1 : 2'd2);
    o.cfo  = (st == 0) || (st == 3);
    o.req  = m_n2;
    o.lk   = m_lk;
    o.n2   = m_n2;
    o.n    = m_n;
    o.lost = m_lost;
    o.miss = 2'(m_miss);
    return o;
  endfunction

  task automatic model(input logic r, input logic rs,
                       input logic sv, input logic p2v,
                       input logic [1:0] p2, input logic nv,
                       input logic [9:0] n);
    int off;
    int sva;
    off    = m_S - m_A;
    sva    = sv ? 1 : 0;
    m_lost = 1'b0;
    if (r) begin
      m_ph = 0; m_miss = 0; m_lk = 1'b0;
      m_n2 = 2'd0; m_n = 10'd0;
    end else if (rs) begin
      m_ph = 0; m_miss = 0; m_lk = 1'b0;
    end else if (m_ph == 0) begin
      if (p2v) begin
        m_n2 = p2; m_A = m_S + sva; m_ph = 1;
      end
    end else if (m_ph == 1) begin
      if (nv) begin
        m_n = n; m_lk = 1'b1; m_miss = 0; m_ph = 2;
      end else if (sv && off == TO - 1) begin
        m_ph = 0;
      end
    end else if (off >= P - H) begin
      if (p2v && p2 == m_n2) begin
        m_A = m_S + sva; m_miss = 0;
      end else if (sv && off == P + H - 1) begin
        m_miss++;
        if (m_miss == MM) begin
          m_ph = 0; m_lk = 1'b0; m_miss = 0; m_lost = 1'b1;
        end else begin
          m_A += P;
        end
      end
    end
    m_S += sva;
  endtask

  task automatic step(input logic r, input logic rs,
                      input logic p2v, input logic [1:0] p2,
                      input logic nv, input logic [9:0] n);
    logic sv;
    int   ph0;
    sv    = sv_ph;
    sv_ph = ~sv_ph;
    rst                = r;
    bus.restart_i      = rs;
    bus.sample_valid_i = sv;
    bus.N_id_2_valid_i = p2v;
    bus.N_id_2_i       = p2;
    bus.N_id_valid_i   = nv;
    bus.N_id_i         = n;
    ph0 = m_ph;
    model(r, rs, sv, p2v, p2, nv, n);
    if (m_ph == 2 && ph0 != 2)
      hitp = ($urandom_range(0, 2) == 0) ? 0 : 12;
    exp_q.push_back(m_obs());
    @(negedge clk);
  endtask

  // one decimated sample, with any events landing on its strobe
  task automatic smp(input logic p2v, input logic [1:0] p2,
                     input logic nv, input logic [9:0] n);
    while (!sv_ph) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 10'd0);
    step(1'b0, 1'b0, p2v, p2, nv, n);
  endtask

  task automatic idle(input int k);
    repeat (k) smp(1'b0, 2'd0, 1'b0, 10'd0);
  endtask

  task automatic run_to(input int off);
    int g;
    g = 0;
    while (m_ph == 2 && (m_S - m_A) != off && g < 400) begin
      smp(1'b0, 2'd0, 1'b0, 10'd0);
      g++;
    end
    if (m_ph != 2 || (m_S - m_A) != off) begin
      miscompares++;
      $display("FAIL run_to: offset %0d not reached (at %0d)",
               off, m_S - m_A);
    end
  endtask

  task automatic chk(input string nm, input int act,
                     input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        obs_t e;
        obs_t a;
        e = exp_q.pop_front();
        a.st   = bus.state_o;
        a.mode = bus.PSS_detector_mode_o;
        a.req  = bus.requested_N_id_2_o;
        a.cfo  = bus.CFO_en_o;
        a.lk   = bus.locked_o;
        a.n2   = bus.N_id_2_o;
        a.n    = bus.N_id_o;
        a.lost = bus.lock_lost_o;
        a.miss = bus.miss_cnt_o;
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display({"FAIL outputs @%0t: got st=%0d mode=%0d req=%0d",
                    " cfo=%0b lk=%0b n2=%0d n=%0d lost=%0b miss=%0d;",
                    " expected st=%0d mode=%0d req=%0d cfo=%0b",
                    " lk=%0b n2=%0d n=%0d lost=%0b miss=%0d"},
                   $time, a.st, a.mode, a.req, a.cfo, a.lk, a.n2,
                   a.n, a.lost, a.miss, e.st, e.mode, e.req, e.cfo,
                   e.lk, e.n2, e.n, e.lost, e.miss);
        end
        if (bus.lock_lost_o === 1'b1) lost_seen++;
      end
    end
  end

  initial begin
    logic       r, rs, p2v, nv;
    logic [1:0] p2;
    logic [9:0] n;
    int         off;

    repeat (3) step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 10'd0);
    chk("reset_state", bus.state_o, 0);
    chk("reset_cfo", bus.CFO_en_o, 1);
    chk("reset_nid", bus.N_id_o, 0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 10'd0);

    // acquire
    smp(1'b1, 2'd1, 1'b0, 10'd0);
    chk("pss_mode_pause", bus.PSS_detector_mode_o, 2);
    chk("pss_cfo_off", bus.CFO_en_o, 0);
    idle(9);
    smp(1'b0, 2'd0, 1'b1, 10'd301);
    chk("acq_locked", bus.locked_o, 1);
    chk("acq_nid", bus.N_id_o, 301);
    chk("acq_state", bus.state_o, 2);
    run_to(P - H - 1);
    idle(1);
    chk("win_mode_track", bus.PSS_detector_mode_o, 1);
    chk("win_req", bus.requested_N_id_2_o, 1);

    // hit at nominal sample 101
    idle(4);
    smp(1'b1, 2'd1, 1'b0, 10'd0);
    chk("track_mode_pause", bus.PSS_detector_mode_o, 2);
    chk("track_miss0", bus.miss_cnt_o, 0);

    // mismatched id ignored, hit on the closing sample
    run_to(P - H - 1);
    idle(1);
    chk("win2_state", bus.state_o, 3);
    smp(1'b1, 2'd2, 1'b0, 10'd0);
    chk("mismatch_ignored", bus.state_o, 3);
    run_to(P + H - 1);
    smp(1'b1, 2'd1, 1'b0, 10'd0);
    chk("close_hit_state", bus.state_o, 2);
    chk("close_hit_miss", bus.miss_cnt_o, 0);

    // three misses
    for (int k = 1; k <= MM; k++) begin
      run_to(P + H - 1);
      idle(1);
      if (k < MM) begin
        chk("miss_cnt", bus.miss_cnt_o, k);
        chk("miss_state", bus.state_o, 2);
      end
    end
    chk("lost_pulse", bus.lock_lost_o, 1);
    chk("lost_state", bus.state_o, 0);
    chk("lost_locked", bus.locked_o, 0);
    chk("lost_miss", bus.miss_cnt_o, 0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 10'd0);
    chk("lost_one_cycle", bus.lock_lost_o, 0);
    chk("lost_count", lost_seen, 1);

    // SSS timeout
    smp(1'b1, 2'd2, 1'b0, 10'd0);
    idle(TO - 1);
    chk("tmo_before", bus.state_o, 1);
    idle(1);
    chk("tmo_state", bus.state_o, 0);
    chk("tmo_locked", bus.locked_o, 0);

    // restart in window
    smp(1'b1, 2'd3, 1'b0, 10'd0);
    idle(5);
    smp(1'b0, 2'd0, 1'b1, 10'd77);
    run_to(P - H + 1);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 10'd0);
    chk("rs_state", bus.state_o, 0);
    chk("rs_locked", bus.locked_o, 0);
    chk("rs_nid_held", bus.N_id_o, 77);
    chk("rs_nid2_held", bus.N_id_2_o, 3);
    chk("rs_no_pulse", bus.lock_lost_o, 0);

    // reset in window
    smp(1'b1, 2'd1, 1'b0, 10'd0);
    smp(1'b0, 2'd0, 1'b1, 10'd500);
    run_to(P - H + 2);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 10'd0);
    chk("rst_state", bus.state_o, 0);
    chk("rst_nid", bus.N_id_o, 0);
    chk("rst_req", bus.requested_N_id_2_o, 0);
    chk("rst_no_pulse", bus.lock_lost_o, 0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 10'd0);

    // randomized traffic
    repeat (30000) begin
      r   = ($urandom_range(0, 3999) == 0);
      rs  = ($urandom_range(0, 699) == 0);
      p2v = 1'b0;
      nv  = 1'b0;
      p2  = 2'($urandom_range(0, 3));
      n   = 10'($urandom_range(0, 1023));
      off = m_S - m_A;
      if (m_ph == 0) begin
        p2v = ($urandom_range(0, 14) == 0);
      end else if (m_ph == 1) begin
        nv  = ($urandom_range(0, 49) == 0);
        p2v = ($urandom_range(0, 29) == 0);
      end else if (off >= P - H) begin
        if ($urandom_range(0, 99) < hitp) begin
          p2v = 1'b1;
          p2  = m_n2;
        end else begin
          p2v = ($urandom_range(0, 19) == 0);
        end
        nv = ($urandom_range(0, 49) == 0);
      end else begin
        p2v = ($urandom_range(0, 99) == 0);
        nv  = ($urandom_range(0, 99) == 0);
      end
      step(r, rs, p2v, p2, nv, n);
    end

    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 10'd0);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
